// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants and types for the data-memory responder
package dmem_pkg;

   localparam logic [3:0] OFS_GPIO   = 4'h0;
   localparam logic [3:0] OFS_CYCLE  = 4'h4;
   localparam logic [3:0] OFS_STATUS = 4'h8;

   localparam int ERR_BIT = 0;

   typedef enum logic [1:0] {
      SEL_RAM  = 2'd0,
      SEL_MMIO = 2'd1,
      SEL_NONE = 2'd2
   } sel_t;

endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - single-port word RAM with byte-lane writes and registered read
module dmem_ram #(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          rd_en,
   input  logic [3:0]    wr_be,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   // The output register only moves on a read, so it holds the last read word.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (wr_be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      if (rd_en) rdata <= mem[addr];
   end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-bus responder: RAM, GPIO, cycle counter and sticky error status
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int                   DATAWIDTH   = 32,
   parameter int                   DEPTH_WORDS = 1024,
   parameter logic [DATAWIDTH-1:0] MMIO_BASE   = 32'h0001_0000
) (
   input  logic                 DMEM_Clk_in,
   input  logic                 DMEM_Reset_in,
   input  logic                 DMEM_Read_in,
   input  logic                 DMEM_Write_in,
   input  logic [3:0]           DMEM_Byteenable_InBUS,
   input  logic [DATAWIDTH-1:0] DMEM_Addr_InBUS,
   input  logic [DATAWIDTH-1:0] DMEM_Writedata_InBUS,
   output logic [DATAWIDTH-1:0] DMEM_Readdata_OutBUS,
   output logic [DATAWIDTH-1:0] DMEM_Gpio_OutBUS,
   output logic                 DMEM_Error_out
);

   localparam int                   AW        = $clog2(DEPTH_WORDS);
   localparam logic [DATAWIDTH-1:0] RAM_BYTES = DATAWIDTH'(DEPTH_WORDS * 4);

   sel_t                 sel;
   logic [3:0]           ofs;
   logic                 rd_only;
   logic                 wr_act;
   logic                 ram_rd;
   logic [3:0]           ram_be;
   logic                 gpio_we;
   logic                 err_w1c;
   logic                 err_set;
   logic [DATAWIDTH-1:0] mmio_rdata;
   logic [DATAWIDTH-1:0] ram_rdata;
   logic [DATAWIDTH-1:0] gpio;
   logic [DATAWIDTH-1:0] cycle_cnt;
   logic                 err;
   logic [DATAWIDTH-1:0] rd_reg;
   logic                 rd_from_ram;

   assign ofs = {DMEM_Addr_InBUS[3:2], 2'b00};

   always_comb begin
      sel = SEL_NONE;
      if (DMEM_Addr_InBUS < RAM_BYTES) begin
         sel = SEL_RAM;
      end else if (DMEM_Addr_InBUS[DATAWIDTH-1:4] == MMIO_BASE[DATAWIDTH-1:4] &&
                   (ofs == OFS_GPIO || ofs == OFS_CYCLE || ofs == OFS_STATUS)) begin
         sel = SEL_MMIO;
      end
   end

   // A combined read+write performs the write only; strobes are dead during reset.
   assign rd_only = DMEM_Reset_in && DMEM_Read_in && !DMEM_Write_in;
   assign wr_act  = DMEM_Reset_in && DMEM_Write_in;
   assign ram_rd  = rd_only && (sel == SEL_RAM);
   assign ram_be  = (wr_act && sel == SEL_RAM) ? DMEM_Byteenable_InBUS : 4'b0000;
   assign gpio_we = wr_act && (sel == SEL_MMIO) && (ofs == OFS_GPIO);
   assign err_w1c = wr_act && (sel == SEL_MMIO) && (ofs == OFS_STATUS) &&
                    DMEM_Byteenable_InBUS[0] && DMEM_Writedata_InBUS[ERR_BIT];
   assign err_set = DMEM_Reset_in &&
                    ((DMEM_Read_in && DMEM_Write_in) ||
                     ((DMEM_Read_in || DMEM_Write_in) && sel == SEL_NONE));

   always_comb begin
      mmio_rdata = '0;
      case (ofs)
         OFS_GPIO:   mmio_rdata = gpio;
         OFS_CYCLE:  mmio_rdata = cycle_cnt;
         OFS_STATUS: mmio_rdata[ERR_BIT] = err;
         default:    mmio_rdata = '0;
      endcase
   end

   dmem_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_ram (
      .clk   (DMEM_Clk_in),
      .rd_en (ram_rd),
      .wr_be (ram_be),
      .addr  (DMEM_Addr_InBUS[AW+1:2]),
      .wdata (DMEM_Writedata_InBUS),
      .rdata (ram_rdata)
   );

   always_ff @(posedge DMEM_Clk_in) begin
      if (!DMEM_Reset_in) begin
         gpio        <= '0;
         cycle_cnt   <= '0;
         err         <= 1'b0;
         rd_reg      <= '0;
         rd_from_ram <= 1'b0;
      end else begin
         cycle_cnt <= cycle_cnt + DATAWIDTH'(1);
         for (int i = 0; i < 4; i++) begin
            if (gpio_we && DMEM_Byteenable_InBUS[i]) gpio[8*i +: 8] <= DMEM_Writedata_InBUS[8*i +: 8];
         end
         // Setting outranks a same-cycle clear.
         if (err_set) err <= 1'b1;
         else if (err_w1c) err <= 1'b0;
         if (rd_only) begin
            rd_from_ram <= (sel == SEL_RAM);
            rd_reg      <= (sel == SEL_MMIO) ? mmio_rdata : '0;
         end
      end
   end

   assign DMEM_Readdata_OutBUS = rd_from_ram ? ram_rdata : rd_reg;
   assign DMEM_Gpio_OutBUS     = gpio;
   assign DMEM_Error_out       = err;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
module tb_dmem_responder;

   logic        clk;
   logic        resetn;
   logic        rd;
   logic        wr;
   logic [3:0]  be;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [31:0] gpio;
   logic        err;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] exp_q[$];

   typedef struct {
      logic        rd;
      logic        wr;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic [31:0] exp_gpio;
      logic        exp_err;
   } vec_t;

   vec_t vecs[$];

   dmem_responder #(
      .DATAWIDTH   (32),
      .DEPTH_WORDS (1024),
      .MMIO_BASE   (32'h0001_0000)
   ) dut (
      .DMEM_Clk_in           (clk),
      .DMEM_Reset_in         (resetn),
      .DMEM_Read_in          (rd),
      .DMEM_Write_in         (wr),
      .DMEM_Byteenable_InBUS (be),
      .DMEM_Addr_InBUS       (addr),
      .DMEM_Writedata_InBUS  (wdata),
      .DMEM_Readdata_OutBUS  (rdata),
      .DMEM_Gpio_OutBUS      (gpio),
      .DMEM_Error_out        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", name, act, expv);
      end
   endtask

   task automatic apply(input logic rst_n, input logic r, input logic w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d);
      resetn = rst_n;
      rd     = r;
      wr     = w;
      be     = b;
      addr   = a;
      wdata  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic r, input logic w, input logic [3:0] b, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] er, input logic [31:0] eg,
                      input logic ee);
      vec_t v;
      v.rd = r; v.wr = w; v.be = b; v.addr = a; v.wdata = d;
      v.exp_rdata = er; v.exp_gpio = eg; v.exp_err = ee;
      vecs.push_back(v);
   endtask

   initial begin
      logic [31:0] e;
      //   rd wr be       addr           wdata          rdata          gpio           err
      for (int i = 0; i < 5; i++)
         add(0, 0, 4'h0, 32'h0,         32'h0,         32'h0,         32'h0,         0);
      add(1, 0, 4'h0, 32'h0001_0004, 32'h0,         32'h5,         32'h0,         0);
      add(0, 1, 4'hF, 32'h0000_0040, 32'hDEAD_BEEF, 32'h5,         32'h0,         0);
      add(0, 1, 4'h2, 32'h0000_0040, 32'h0000_1200, 32'h5,         32'h0,         0);
      add(1, 0, 4'h0, 32'h0000_0040, 32'h0,         32'hDEAD_12EF, 32'h0,         0);
      add(0, 1, 4'h1, 32'h0001_0000, 32'h0000_00A5, 32'hDEAD_12EF, 32'h0000_00A5, 0);
      add(0, 1, 4'h0, 32'h0001_0000, 32'hFFFF_FFFF, 32'hDEAD_12EF, 32'h0000_00A5, 0);
      add(1, 0, 4'h0, 32'h0001_0000, 32'h0,         32'h0000_00A5, 32'h0000_00A5, 0);
      add(0, 1, 4'hC, 32'h0001_0000, 32'h1234_5678, 32'h0000_00A5, 32'h1234_00A5, 0);
      add(0, 1, 4'hF, 32'h0001_0004, 32'hFFFF_FFFF, 32'h0000_00A5, 32'h1234_00A5, 0);
      add(1, 0, 4'h0, 32'h0000_8000, 32'h0,         32'h0,         32'h1234_00A5, 1);
      add(1, 0, 4'h0, 32'h0001_0008, 32'h0,         32'h1,         32'h1234_00A5, 1);
      add(0, 1, 4'h1, 32'h0001_0008, 32'h0,         32'h1,         32'h1234_00A5, 1);
      add(0, 1, 4'h2, 32'h0001_0008, 32'h1,         32'h1,         32'h1234_00A5, 1);
      add(0, 1, 4'h1, 32'h0001_0008, 32'h1,         32'h1,         32'h1234_00A5, 0);
      add(1, 0, 4'h0, 32'h0001_000C, 32'h0,         32'h0,         32'h1234_00A5, 1);
      add(0, 1, 4'h1, 32'h0001_0008, 32'h1,         32'h0,         32'h1234_00A5, 0);
      add(1, 1, 4'h1, 32'h0001_0008, 32'h1,         32'h0,         32'h1234_00A5, 1);
      add(0, 1, 4'h1, 32'h0001_0008, 32'h1,         32'h0,         32'h1234_00A5, 0);
      add(1, 1, 4'hF, 32'h0000_0010, 32'h1234_5678, 32'h0,         32'h1234_00A5, 1);
      add(1, 0, 4'h0, 32'h0000_0010, 32'h0,         32'h1234_5678, 32'h1234_00A5, 1);
      add(0, 1, 4'h1, 32'h0001_0008, 32'h1,         32'h1234_5678, 32'h1234_00A5, 0);
      add(0, 1, 4'hF, 32'h0002_0000, 32'hFFFF_FFFF, 32'h1234_5678, 32'h1234_00A5, 1);
      add(0, 1, 4'hF, 32'h0000_0FFC, 32'hA1B2_C3D4, 32'h1234_5678, 32'h1234_00A5, 1);
      add(1, 0, 4'h0, 32'h0000_0FFE, 32'h0,         32'hA1B2_C3D4, 32'h1234_00A5, 1);
      add(1, 0, 4'h0, 32'h0000_1000, 32'h0,         32'h0,         32'h1234_00A5, 1);
      add(1, 0, 4'h0, 32'h0001_0003, 32'h0,         32'h1234_00A5, 32'h1234_00A5, 1);

      apply(0, 1, 1, 4'hF, 32'h0, 32'h0);
      apply(0, 0, 0, 4'h0, 32'h0, 32'h0);
      check("reset_rdata", rdata, 32'h0);
      check("reset_gpio", gpio, 32'h0);
      check("reset_err", {31'h0, err}, 32'h0);

      for (int i = 0; i < vecs.size(); i++) begin
         exp_q.push_back(vecs[i].exp_rdata);
         apply(1, vecs[i].rd, vecs[i].wr, vecs[i].be, vecs[i].addr, vecs[i].wdata);
         e = exp_q.pop_front();
         check($sformatf("vec%0d_rdata", i), rdata, e);
         check($sformatf("vec%0d_gpio", i), gpio, vecs[i].exp_gpio);
         check($sformatf("vec%0d_err", i), {31'h0, err}, {31'h0, vecs[i].exp_err});
      end

      // Counter wrap: deposit all-ones, one idle edge wraps it, then two CYCLE reads.
      dut.cycle_cnt = 32'hFFFF_FFFF;
      apply(1, 0, 0, 4'h0, 32'h0, 32'h0);
      exp_q.push_back(32'h0);
      apply(1, 1, 0, 4'h0, 32'h0001_0004, 32'h0);
      check("cycle_wrap", rdata, exp_q.pop_front());
      exp_q.push_back(32'h1);
      apply(1, 1, 0, 4'h0, 32'h0001_0004, 32'h0);
      check("cycle_after_wrap", rdata, exp_q.pop_front());

      // A write presented during reset is dropped; error and GPIO clear.
      apply(1, 0, 1, 4'hF, 32'h0000_0080, 32'h1111_1111);
      apply(0, 1, 1, 4'hF, 32'h0000_0080, 32'hBAD0_BAD0);
      check("rst_write_rdata", rdata, 32'h0);
      check("rst_write_gpio", gpio, 32'h0);
      check("rst_write_err", {31'h0, err}, 32'h0);
      apply(0, 0, 1, 4'h3, 32'h0000_0080, 32'hBAD0_BAD0);
      exp_q.push_back(32'h1111_1111);
      apply(1, 1, 0, 4'h0, 32'h0000_0080, 32'h0);
      check("rst_write_dropped", rdata, exp_q.pop_front());
      check("rst_write_no_err", {31'h0, err}, 32'h0);
      apply(1, 0, 0, 4'h0, 32'h0, 32'h0);
      check("idle_hold", rdata, 32'h1111_1111);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the core's data bus: read strobe, write strobe, 4-bit byte enable, byte address and write data in; read data out.
- Contains a word-organised RAM with per-byte-lane writes and a small memory-mapped I/O (MMIO) window: GPIO output register, free-running cycle counter, sticky error/status register.
- Sits beside the core on the data bus, opposite end of the core's load/store path. Sub-word lane selection and sign extension stay in the core's LSU; this block always returns full words.

Parameters:
- DATAWIDTH, 32, data bus and address width.
- DEPTH_WORDS, 1024, RAM depth in 32-bit words; power of two; RAM occupies byte addresses 0 .. DEPTH_WORDS*4-1.
- MMIO_BASE, 32'h0001_0000, base byte address of the MMIO window; 16-byte aligned; must lie above the RAM region.

Ports:
- DMEM_Clk_in  in  1  clock; all state updates on the rising edge.
- DMEM_Reset_in  in  1  reset, synchronous, active-low.
- DMEM_Read_in  in  1  read strobe.
- DMEM_Write_in  in  1  write strobe.
- DMEM_Byteenable_InBUS  in  4  bit i enables byte lane i = data bits [8i+7:8i].
- DMEM_Addr_InBUS  in  DATAWIDTH  byte address; bits [1:0] ignored (word access).
- DMEM_Writedata_InBUS  in  DATAWIDTH  write data, already lane-aligned.
- DMEM_Readdata_OutBUS  out  DATAWIDTH  registered read data.
- DMEM_Gpio_OutBUS  out  DATAWIDTH  GPIO output register.
- DMEM_Error_out  out  1  sticky access error flag (mirror of status bit 0).

Behaviour:
- Reset (DMEM_Reset_in=0 at an edge): Readdata=0, Gpio=0, cycle counter=0, error=0. RAM contents are not reset. Strobes are ignored in a reset cycle; a write presented during reset is dropped.
- Address decode on word address A = Addr[DATAWIDTH-1:2]:
  - RAM when Addr < DEPTH_WORDS*4.
  - MMIO when Addr[DATAWIDTH-1:4] == MMIO_BASE[DATAWIDTH-1:4], at offsets 0x0, 0x4 and 0x8.
  - Everything else is unmapped, including MMIO offset 0xC.
- MMIO map:
  - 0x0 GPIO: RW, byte-enabled.
  - 0x4 CYCLE: RO; writes are ignored without error.
  - 0x8 STATUS: bit0 = error. A write with lane 0 enabled and data bit0=1 clears it (W1C). Other bits read 0.
- Write (Write=1, Read=0): at the edge, each enabled lane of the target RAM word or GPIO is updated. Byteenable 4'b0000 means no change. Readdata holds.
- Read (Read=1, Write=0): Readdata is loaded at the edge with the full target word. Latency is one cycle: data is valid the cycle after the strobe and held until the next read.
- Idle (both 0): Readdata holds its value; no state changes except the counter.
- Read and write both asserted: the write is performed, the read is ignored (Readdata holds), and error is set.
- Unmapped access (read or write): no storage changes. For a read, Readdata is loaded with 0. Error is set.
- Error is sticky until a W1C to STATUS or reset. Error set and W1C in the same cycle: set wins.
- Cycle counter:
  - Increments by 1 every non-reset cycle and wraps from 32'hFFFF_FFFF to 0.
  - A CYCLE read returns the counter value before that edge's increment.
- Writing GPIO then reading GPIO in the next cycle returns the new value; no forwarding issue, because the write completes at the edge.

Decomposition:
- Shared package (dmem_pkg):
  - MMIO offset constants: OFS_GPIO=4'h0, OFS_CYCLE=4'h4, OFS_STATUS=4'h8.
  - STATUS bit index ERR_BIT=0.
  - The region-select enumeration {SEL_RAM, SEL_MMIO, SEL_NONE}.
- Natural sub-module: dmem_ram.
  - Single-port, DEPTH_WORDS×32, four byte lanes with per-lane write enables, registered read.
  - Infers block RAM.
  - The top level holds the decode logic, MMIO registers, counter, read-data mux and error logic.

Test Plan:
- Reset then idle 5 cycles: Readdata=0, Gpio=0, Error=0. A CYCLE read issued in the 6th post-reset cycle returns 5.
- Write 32'hDEAD_BEEF to addr 0x40 with BE=4'hF, then write 32'h0000_1200 with BE=4'b0010, then read 0x40: Readdata=32'hDEAD_12EF one cycle after the read strobe.
- Write 32'h0000_00A5 to MMIO_BASE+0 with BE=4'b0001: Gpio=32'h0000_00A5 the cycle after. A later write with BE=4'b0000: Gpio unchanged.
- Read unmapped addr 32'h0000_8000 (DEPTH_WORDS=1024): Readdata=0 and Error=1. Then write 1 to MMIO_BASE+8 with BE=4'b0001: Error=0. Repeat with the unmapped access in the same cycle as the W1C: Error stays 1.
- Assert Read and Write together to addr 0x10 with data 32'h1234_5678: RAM[4]=32'h1234_5678, Readdata holds, Error=1.
- Start a RAM write with DMEM_Reset_in=0 in the same cycle: RAM is unchanged, verified by a later read. Force the counter to 32'hFFFF_FFFF (bench hierarchical deposit) and step: the next CYCLE read returns 0.
